// File: rtl/audio_intensity_meter.sv
// Windowed audio magnitude meter: averages |sample| over 2^LOG2_WINDOW accepted samples and
// drives a thermometer LED bar, optionally with peak hold and timed decay.
module audio_intensity_meter #(
  parameter int unsigned SAMPLE_W      = 8,
  parameter int unsigned LOG2_WINDOW   = 8,
  parameter int unsigned NUM_LEDS      = 8,
  parameter int unsigned DECAY_WINDOWS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                peak_mode,
  output logic [SAMPLE_W-2:0] level,
  output logic                level_valid,
  output logic [NUM_LEDS-1:0] intensity
);

  localparam int unsigned MagW  = SAMPLE_W - 1;
  localparam int unsigned AccW  = MagW + LOG2_WINDOW;
  localparam int unsigned LitW  = $clog2(NUM_LEDS + 1);
  localparam int unsigned ProdW = MagW + $clog2(NUM_LEDS + 2);
  localparam int unsigned DecW  = (DECAY_WINDOWS > 1) ? $clog2(DECAY_WINDOWS) : 1;

  logic [MagW-1:0]        mag;
  logic [AccW-1:0]        acc_q, win_sum_q;
  logic [LOG2_WINDOW-1:0] cnt_q;
  logic                   s1_valid_q, s2_valid_q;
  logic [MagW-1:0]        avg, avg_q;
  logic [ProdW-1:0]       prod, lit_raw;
  logic [LitW-1:0]        lit, lit_q;
  logic [LitW-1:0]        peak_q, peak_d, shown;
  logic [DecW-1:0]        decay_q, decay_d;
  logic [NUM_LEDS-1:0]    bar;

  // Most-negative code has no positive twin, so it saturates to full scale.
  always_comb begin
    if (sample_data[SAMPLE_W-1]) begin
      if (sample_data[SAMPLE_W-2:0] == '0) begin
        mag = '1;
      end else begin
        mag = MagW'(-sample_data);
      end
    end else begin
      mag = sample_data[SAMPLE_W-2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      win_sum_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= 1'b0;
      if (sample_valid) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '1) begin
          win_sum_q  <= acc_q + AccW'(mag);
          acc_q      <= '0;
          s1_valid_q <= 1'b1;
        end else begin
          acc_q <= acc_q + AccW'(mag);
        end
      end
    end
  end

  // Stage 1: truncated average and scaled LED count.
  always_comb begin
    avg     = win_sum_q[AccW-1:LOG2_WINDOW];
    prod    = ProdW'(avg) * ProdW'(NUM_LEDS + 1);
    lit_raw = prod >> (SAMPLE_W - 1);
    lit     = (lit_raw > ProdW'(NUM_LEDS)) ? LitW'(NUM_LEDS) : LitW'(lit_raw);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avg_q      <= '0;
      lit_q      <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        avg_q <= avg;
        lit_q <= lit;
      end
    end
  end

  // Stage 2: peak tracking runs every window so switching modes shows a current peak.
  always_comb begin
    peak_d  = peak_q;
    decay_d = decay_q;
    if (lit_q >= peak_q) begin
      peak_d  = lit_q;
      decay_d = '0;
    end else if (decay_q == DecW'(DECAY_WINDOWS - 1)) begin
      peak_d  = peak_q - 1'b1;
      decay_d = '0;
    end else begin
      decay_d = decay_q + 1'b1;
    end
    shown = peak_mode ? peak_d : lit_q;
    bar   = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      bar[i] = (i >= NUM_LEDS - 32'(shown));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level       <= '0;
      level_valid <= 1'b0;
      intensity   <= '0;
      peak_q      <= '0;
      decay_q     <= '0;
    end else begin
      level_valid <= s2_valid_q;
      if (s2_valid_q) begin
        level     <= avg_q;
        intensity <= bar;
        peak_q    <= peak_d;
        decay_q   <= decay_d;
      end
    end
  end

endmodule

// File: tb/tb_audio_intensity_meter.sv
// Randomised and directed bench for audio_intensity_meter against a window-level reference model.
module tb_audio_intensity_meter;

  localparam int Window = 256;
  localparam int Leds   = 8;
  localparam int Decay  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_data = '0;
  logic       peak_mode = 1'b0;
  logic [6:0] level;
  logic       level_valid;
  logic [7:0] intensity;

  audio_intensity_meter dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .peak_mode   (peak_mode),
    .level       (level),
    .level_valid (level_valid),
    .intensity   (intensity)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int avg;
    int lit;
  } upd_t;

  upd_t pend[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int win_sum = 0, win_n = 0;
  int peak = 0, decay = 0;
  int exp_level = 0, exp_int = 0, exp_valid = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int mag_of(input int d);
    if (d == -128) return 127;
    return (d < 0) ? -d : d;
  endfunction

  function automatic int bar_of(input int n);
    return ((1 << n) - 1) << (Leds - n);
  endfunction

  // One clock: apply inputs, let the edge happen, advance the model, then compare.
  task automatic step(input bit r, input bit v, input int d);
    upd_t e;
    int a, l;
    reset        = r;
    sample_valid = v;
    sample_data  = d[7:0];
    @(posedge clk);
    cyc++;
    if (r) begin
      win_sum = 0; win_n = 0; pend.delete();
      peak = 0; decay = 0;
      exp_level = 0; exp_int = 0; exp_valid = 0;
    end else begin
      exp_valid = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
        if (e.lit >= peak) begin
          peak = e.lit; decay = 0;
        end else if (decay == Decay - 1) begin
          peak = peak - 1; decay = 0;
        end else begin
          decay = decay + 1;
        end
        exp_level = e.avg;
        exp_int   = bar_of(peak_mode ? peak : e.lit);
        exp_valid = 1;
      end
      if (v) begin
        win_sum += mag_of(d);
        win_n++;
        if (win_n == Window) begin
          a = win_sum / Window;
          l = (a * (Leds + 1)) / 128;
          if (l > Leds) l = Leds;
          e.due = cyc + 2; e.avg = a; e.lit = l;
          pend.push_back(e);
          win_sum = 0; win_n = 0;
        end
      end
    end
    #1;
    check("level_valid", int'(level_valid), exp_valid);
    check("level", int'(level), exp_level);
    check("intensity", int'(intensity), exp_int);
  endtask

  task automatic run_const(input int n, input int d);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  initial begin
    // Reset, then +64 window
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    run_const(Window, 64);
    idle(4);
    // Saturating most-negative code, then silence
    run_const(Window, -128);
    run_const(Window, 0);
    idle(4);
    // Valid toggling every cycle with alternating sign
    for (int i = 0; i < 2 * Window; i++) begin
      step(1'b0, (i % 2) == 0, ((i / 2) % 2) ? -100 : 100);
    end
    idle(4);
    // Back-to-back windows
    run_const(Window, 15);
    run_const(Window, 14);
    idle(4);
    // Peak hold with decay, then live mode
    peak_mode = 1'b1;
    run_const(Window, 127);
    for (int w = 0; w < 8; w++) run_const(Window, 0);
    idle(4);
    peak_mode = 1'b0;
    run_const(Window, 127);
    run_const(Window, 0);
    idle(4);
    // Reset mid-window discards the partial sum
    run_const(100, 127);
    step(1'b1, 1'b1, 127);
    run_const(Window, 32);
    idle(4);
    // Random samples, gaps and mode flips
    for (int i = 0; i < 6 * Window * 4 / 3; i++) begin
      if ($urandom_range(0, 63) == 0) peak_mode = ~peak_mode;
      step(1'b0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)) - 128);
    end
    idle(4);
    check("pending_updates", pend.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
